// File: rtl/jk_cmd_pkg.sv
// jk_cmd_pkg: shared types for the JK command sequencer.
// Op and FSM enums, j/k encoding and expected-Q helpers.
package jk_cmd_pkg;

  typedef enum logic [1:0] {
    OP_HOLD   = 2'd0,
    OP_SET    = 2'd1,
    OP_CLEAR  = 2'd2,
    OP_TOGGLE = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_CHECK = 2'd2
  } state_e;

  // returns {j, k}
  function automatic logic [1:0] jk_enc(input op_e op);
    logic [1:0] v;
    v = 2'b00;
    case (op)
      OP_HOLD:   v = 2'b00;
      OP_SET:    v = 2'b10;
      OP_CLEAR:  v = 2'b01;
      OP_TOGGLE: v = 2'b11;
      default:   v = 2'b00;
    endcase
    return v;
  endfunction

  function automatic logic jk_expect(
    input op_e  op,
    input logic q_prev
  );
    logic v;
    v = q_prev;
    case (op)
      OP_HOLD:   v = q_prev;
      OP_SET:    v = 1'b1;
      OP_CLEAR:  v = 1'b0;
      OP_TOGGLE: v = ~q_prev;
      default:   v = q_prev;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/jk_cmd_fifo.sv
// jk_cmd_fifo: synchronous command FIFO, power-of-two depth.
// Registered occupancy; head is read combinationally.
module jk_cmd_fifo #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          push,
  input  logic [1:0]                    wdata,
  input  logic                          pop,
  output logic [1:0]                    rdata,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  logic [1:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic          w_push;
  logic          w_pop;

  assign full  = (r_count == CW'(FIFO_DEPTH));
  assign empty = (r_count == '0);
  assign count = r_count;
  assign rdata = r_mem[r_rptr];

  assign w_push = push && !full;
  assign w_pop  = pop && !empty;

  // pointers and occupancy; reset discards contents
  always_ff @(posedge clock) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push)
        r_wptr <= r_wptr + AW'(1);
      if (w_pop)
        r_rptr <= r_rptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // storage write
  always_ff @(posedge clock) begin
    if (w_push)
      r_mem[r_wptr] <= wdata;
  end

endmodule

// File: rtl/jk_flip_flop.sv
// jk_flip_flop: plain JK flip-flop with synchronous active-high reset.
// Downstream target driven by the command sequencer.
module jk_flip_flop (
  input  logic clock,
  input  logic reset,
  input  logic j,
  input  logic k,
  output logic q
);

  // JK next-state
  always_ff @(posedge clock) begin
    if (reset)
      q <= 1'b0;
    else begin
      case ({j, k})
        2'b10:   q <= 1'b1;
        2'b01:   q <= 1'b0;
        2'b11:   q <= ~q;
        default: q <= q;
      endcase
    end
  end

endmodule

// File: rtl/jk_cmd_sequencer.sv
// jk_cmd_sequencer: queues JK commands and drives j/k one cycle each.
// Macro JK_CMD_FEEDBACK_CHECK_EN enables the q feedback check on err.
module jk_cmd_sequencer
  import jk_cmd_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       cmd_valid,
  input  logic [1:0] cmd_op,
  output logic       cmd_ready,
  output logic       j,
  output logic       k,
  input  logic       q,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  state_e        r_state;
  state_e        w_next;
  op_e           r_op;
  logic          r_j;
  logic          r_k;
  logic          w_pop;
  logic          w_done;
  logic          w_full;
  logic          w_empty;
  logic [1:0]    w_head;
  logic [CW-1:0] w_count;

  jk_cmd_fifo #(
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (cmd_valid),
    .wdata (cmd_op),
    .pop   (w_pop),
    .rdata (w_head),
    .full  (w_full),
    .empty (w_empty),
    .count (w_count)
  );

  assign cmd_ready = !w_full;
  assign busy      = (r_state != ST_IDLE) || (w_count != '0);
  assign done      = w_done;
  assign j         = r_j;
  assign k         = r_k;

  // state register
  always_ff @(posedge clock) begin
    if (reset)
      r_state <= ST_IDLE;
    else
      r_state <= w_next;
  end

  // next state, pop and done
  always_comb begin
    w_next = r_state;
    w_pop  = 1'b0;
    w_done = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (!w_empty) begin
          w_pop  = 1'b1;
          w_next = ST_DRIVE;
        end
      end
      ST_DRIVE: w_next = ST_CHECK;
      ST_CHECK: begin
        w_done = 1'b1;
        w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // latch popped op; j/k high only for the DRIVE cycle
  always_ff @(posedge clock) begin
    if (reset) begin
      r_op <= OP_HOLD;
      r_j  <= 1'b0;
      r_k  <= 1'b0;
    end else if (w_pop) begin
      r_op       <= op_e'(w_head);
      {r_j, r_k} <= jk_enc(op_e'(w_head));
    end else begin
      r_j <= 1'b0;
      r_k <= 1'b0;
    end
  end

`ifdef JK_CMD_FEEDBACK_CHECK_EN
  logic r_q_prev;

  // q before the JK edge, used to predict the post-edge value
  always_ff @(posedge clock) begin
    if (reset)
      r_q_prev <= 1'b0;
    else if (r_state == ST_DRIVE)
      r_q_prev <= q;
  end

  assign err = w_done && (q != jk_expect(r_op, r_q_prev));
`else
  logic w_unused_q;

  assign w_unused_q = q;
  assign err        = 1'b0;
`endif

endmodule

// File: tb/tb_jk_cmd_sequencer.sv
// tb_jk_cmd_sequencer: directed bench for the JK command sequencer.
// Drives a real jk_flip_flop and checks vector tables plus corner cases.
module tb_jk_cmd_sequencer;
  import jk_cmd_pkg::*;

`ifdef JK_CMD_FEEDBACK_CHECK_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       cmd_valid = 1'b0;
  logic [1:0] cmd_op = 2'd0;
  logic       cmd_ready;
  logic       j;
  logic       k;
  logic       busy;
  logic       done;
  logic       err;
  logic       ff_q;
  logic       dut_q;
  logic       force_q = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  assign dut_q = force_q ? 1'b0 : ff_q;

  always #5 clock = ~clock;

  jk_cmd_sequencer #(
    .FIFO_DEPTH(4)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_op    (cmd_op),
    .cmd_ready (cmd_ready),
    .j         (j),
    .k         (k),
    .q         (dut_q),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  jk_flip_flop u_ff (
    .clock (clock),
    .reset (reset),
    .j     (j),
    .k     (k),
    .q     (ff_q)
  );

  typedef struct {
    logic       v;
    logic [1:0] op;
    logic [6:0] exp; // {ready,j,k,busy,done,err,q}
  } vec_t;

  vec_t vecs[16];

  logic [1:0] ops2[7];
  logic [1:0] exp_jk2[7];
  logic [1:0] got_jk[$];
  logic [1:0] prev_jk;
  int         ndone;
  bit         saw_low;
  bit         saw_err;
  bit         acc;
  int         guard;

  task automatic chk(
    input string       name,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset;
    cmd_valid = 1'b0;
    force_q   = 1'b0;
    reset     = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    vecs[0]  = '{1'b1, OP_SET,    7'b1001000};
    vecs[1]  = '{1'b1, OP_CLEAR,  7'b1101000};
    vecs[2]  = '{1'b1, OP_TOGGLE, 7'b1001101};
    vecs[3]  = '{1'b1, OP_TOGGLE, 7'b1001001};
    vecs[4]  = '{1'b1, OP_HOLD,   7'b1011001};
    vecs[5]  = '{1'b0, OP_HOLD,   7'b1001100};
    vecs[6]  = '{1'b0, OP_HOLD,   7'b1001000};
    vecs[7]  = '{1'b0, OP_HOLD,   7'b1111000};
    vecs[8]  = '{1'b0, OP_HOLD,   7'b1001101};
    vecs[9]  = '{1'b0, OP_HOLD,   7'b1001001};
    vecs[10] = '{1'b0, OP_HOLD,   7'b1111001};
    vecs[11] = '{1'b0, OP_HOLD,   7'b1001100};
    vecs[12] = '{1'b0, OP_HOLD,   7'b1001000};
    vecs[13] = '{1'b0, OP_HOLD,   7'b1001000};
    vecs[14] = '{1'b0, OP_HOLD,   7'b1001100};
    vecs[15] = '{1'b0, OP_HOLD,   7'b1000000};

    ops2    = '{OP_SET, OP_TOGGLE, OP_CLEAR, OP_HOLD,
                OP_TOGGLE, OP_SET, OP_CLEAR};
    exp_jk2 = '{2'b10, 2'b11, 2'b01, 2'b00,
                2'b11, 2'b10, 2'b01};

    // reset held two cycles, idle outputs afterwards
    do_reset();
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("rst_idle%0d", c),
          {cmd_ready, j, k, busy, done, err},
          6'b100000);
      tick();
    end

    // back-to-back SET CLEAR TOGGLE TOGGLE HOLD
    do_reset();
    for (int i = 0; i < 16; i++) begin
      cmd_valid = vecs[i].v;
      cmd_op    = vecs[i].op;
      tick();
      chk($sformatf("vec%0d", i),
          {cmd_ready, j, k, busy, done, err, ff_q},
          vecs[i].exp);
    end
    cmd_valid = 1'b0;

    // overfill with valid held until accepted
    do_reset();
    got_jk.delete();
    ndone   = 0;
    saw_low = 1'b0;
    saw_err = 1'b0;
    prev_jk = 2'b00;
    fork
      begin
        for (int i = 0; i < 7; i++) begin
          cmd_valid = 1'b1;
          cmd_op    = ops2[i];
          acc       = 1'b0;
          guard     = 0;
          while (!acc && guard < 40) begin
            acc = cmd_ready;
            tick();
            guard++;
          end
          chk($sformatf("push_acc%0d", i), 32'(acc), 1);
        end
        cmd_valid = 1'b0;
      end
      begin
        for (int c = 0; c < 120 && ndone < 7; c++) begin
          tick();
          if (done) begin
            got_jk.push_back(prev_jk);
            ndone++;
          end
          if (err)
            saw_err = 1'b1;
          if (!cmd_ready)
            saw_low = 1'b1;
          prev_jk = {j, k};
        end
      end
    join
    chk("fill_ndone", 32'(ndone), 7);
    chk("fill_ready_low", 32'(saw_low), 1);
    chk("fill_no_err", 32'(saw_err), 0);
    chk("fill_q_final", 32'(ff_q), 0);
    for (int i = 0; i < 7; i++) begin
      if (i < got_jk.size())
        chk($sformatf("order%0d", i), 32'(got_jk[i]), 32'(exp_jk2[i]));
      else
        chk($sformatf("order%0d", i), 32'hdead, 32'(exp_jk2[i]));
    end

    // q forced low during a SET
    do_reset();
    force_q   = 1'b1;
    cmd_valid = 1'b1;
    cmd_op    = OP_SET;
    tick();
    cmd_valid = 1'b0;
    chk("force_idle", {done, err}, 2'b00);
    tick();
    chk("force_drive", {j, k, done, err}, 4'b1000);
    tick();
    chk("force_done", 32'(done), 1);
    chk("force_err", 32'(err), 32'(EXP_ERR));
    tick();
    chk("force_after", {done, err}, 2'b00);
    force_q = 1'b0;

    // reset during DRIVE with three queued
    do_reset();
    cmd_valid = 1'b1;
    cmd_op    = OP_SET;    tick();
    cmd_op    = OP_CLEAR;  tick();
    cmd_op    = OP_TOGGLE; tick();
    cmd_op    = OP_SET;    tick();
    cmd_op    = OP_TOGGLE; tick();
    cmd_valid = 1'b0;
    chk("mid_drive", {j, k, busy}, 3'b011);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_rst", {j, k, done, busy, cmd_ready}, 5'b00001);
    for (int c = 0; c < 6; c++) begin
      tick();
      chk($sformatf("post_rst%0d", c),
          {j, k, done, err, busy, cmd_ready},
          6'b000001);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/jk_cmd_sequencer.md
JK_CMD_SEQUENCER -- requirements
Module: jk_cmd_sequencer

Interface
REQ-001 Parameter FIFO_DEPTH, 4, command FIFO entries; power of two, 2..16.
REQ-002 clock  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high; sampled on rising edge of clock.
REQ-004 cmd_valid  input  1  command present on cmd_op.
REQ-005 cmd_op  input  2  0=HOLD, 1=SET, 2=CLEAR, 3=TOGGLE.
REQ-006 cmd_ready  output  1  FIFO not full; push occurs when cmd_valid && cmd_ready.
REQ-007 j  output  1  registered J drive to downstream JK flip-flop.
REQ-008 k  output  1  registered K drive to downstream JK flip-flop.
REQ-009 q  input  1  feedback from downstream JK flip-flop Q.
REQ-010 busy  output  1  high whenever FSM is not IDLE or the FIFO is non-empty.
REQ-011 done  output  1  one-cycle pulse per completed command.
REQ-012 err  output  1  one-cycle pulse, coincident with done, on feedback mismatch.

Function
REQ-013 FSM states IDLE, DRIVE, CHECK; one command takes exactly 3 cycles from pop to return to IDLE.
REQ-014 IDLE: if FIFO non-empty, pop head, register op, go DRIVE; else stay IDLE.
REQ-015 DRIVE: j/k registered outputs encode op (HOLD 0/0, SET 1/0, CLEAR 0/1, TOGGLE 1/1) for exactly one cycle; q sampled into q_prev.
REQ-016 CHECK: j=k=0; expected = SET:1, CLEAR:0, TOGGLE:~q_prev, HOLD:q_prev; done=1; go IDLE.
REQ-017 j and k are 0 in every state except DRIVE; never asserted for two consecutive cycles.
REQ-018 done asserts in the cycle after DRIVE; latency from accepted push into an empty idle block to done = 3 cycles.
REQ-019 FIFO full: cmd_ready=0; cmd_valid ignored, no overwrite.
REQ-020 Push and pop in same cycle: both take effect; occupancy unchanged.
REQ-021 Push into empty FIFO while IDLE: entry visible to IDLE pop on the next cycle (no bypass).
REQ-022 Commands execute strictly in push order; occupancy counter width clog2(FIFO_DEPTH)+1, pointers wrap modulo FIFO_DEPTH.

Reset
REQ-023 reset dominates all other inputs in the same cycle.
REQ-024 After reset: state IDLE, FIFO empty, j=0, k=0, done=0, err=0, busy=0, cmd_ready=1.
REQ-025 Reset mid-command (DRIVE or CHECK): command abandoned, no done/err pulse, FIFO contents discarded.

Configuration
REQ-026 Macro JK_CMD_FEEDBACK_CHECK_EN defined: err=1 in CHECK when q != expected.
REQ-027 Macro undefined: q unused, q_prev register omitted, err tied to 0; FSM timing and done unchanged.

Structure
REQ-028 Package jk_cmd_pkg holds the op enum (HOLD/SET/CLEAR/TOGGLE), FSM state enum, and j/k encoding function.
REQ-029 FIFO is a sub-module jk_cmd_fifo (synchronous, parameterized depth, push/pop/full/empty/count).
REQ-030 Bench pairs the block with the team's jk_flip_flop sharing clock and reset, j/k/q connected.

Verification
REQ-031 Reset held 2 cycles, then released -> j=k=0, cmd_ready=1, busy=0, done=0 every cycle until first push.
REQ-032 Push SET, CLEAR, TOGGLE, TOGGLE, HOLD back-to-back -> j/k pulses 10,01,11,11,00 three cycles apart; q sequence 1,0,1,0,0; 5 done pulses, err never high.
REQ-033 Push 5 commands with no gaps at FIFO_DEPTH=4 -> cmd_ready low when 4 entries held and no pop that cycle; no push lost when stimulus holds cmd_valid until accepted; order preserved.
REQ-034 With JK_CMD_FEEDBACK_CHECK_EN defined, force q=0 during a SET command -> done and err both pulse in the CHECK cycle; err=0 on all others.
REQ-035 Same forcing without the macro -> done pulses, err stays 0.
REQ-036 Assert reset in the DRIVE cycle with 3 commands queued -> next cycle j=k=0, no done pulse, busy=0, cmd_ready=1.
